// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status bundle for uart_tx_fifo.
// The master modport is the word producer; the slave modport is the transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          i_Tx_DV;
  logic [DATA_BITS-1:0]          i_Tx_Byte;
  logic                          o_Tx_Ready;
  logic                          o_Tx_Serial;
  logic                          o_Tx_Active;
  logic                          o_Tx_Done;
  logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format and a transmit FIFO.
// Queued words are sent LSB-first, back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5000,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic           i_Clock,
  input logic           i_Reset,
  uart_tx_fifo_if.slave tx_if
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]      count_q;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop, empty, full, bit_end, last_stop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == LvlW'(FIFO_DEPTH));
  assign push      = tx_if.i_Tx_DV & ~full;
  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign last_stop = (state_q == StStop) && bit_end && (stop_idx_q == 1'(STOP_BITS - 1));
  // Pop only from a sampled count, so a word pushed into an empty FIFO waits one edge.
  assign pop       = ~empty & ((state_q == StIdle) | last_stop);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + LvlW'(1);
      else if (pop && !push) count_q <= count_q - LvlW'(1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_if.i_Tx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    if (state_q != StIdle) clk_cnt_d = bit_end ? '0 : clk_cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d   = StStart;
          clk_cnt_d = '0;
          shift_d   = head;
          parity_d  = (^head) ^ (PARITY == 1);
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d    = (PARITY != 0) ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (last_stop) begin
          if (pop) begin
            state_d  = StStart;
            shift_d  = head;
            parity_d = (^head) ^ (PARITY == 1);
          end else begin
            state_d = StIdle;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_d[0];
      StParity: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
    active_d = (state_d != StIdle);
    done_d   = last_stop;
  end

  assign tx_if.o_Tx_Ready   = ~full;
  assign tx_if.o_Tx_Serial  = serial_q;
  assign tx_if.o_Tx_Active  = active_q;
  assign tx_if.o_Tx_Done    = done_q;
  assign tx_if.o_Fifo_Count = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7E1/7O1 and 8N2 instances at 4 clocks per bit.
module tb_uart_tx_fifo;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] words [6];

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if3 ();

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8n1 (.i_Clock(clk), .i_Reset(rst), .tx_if(if0.slave));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_7e1 (.i_Clock(clk), .i_Reset(rst), .tx_if(if1.slave));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_7o1 (.i_Clock(clk), .i_Reset(rst), .tx_if(if2.slave));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_8n2 (.i_Clock(clk), .i_Reset(rst), .tx_if(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k samples after the first pop for five queued 8N1 frames.
  function automatic logic fifo_bit(input int k);
    int f;
    int b;
    logic [7:0] w;
    if (k > 200) return 1'b1;
    f = (k - 1) / 40;
    b = ((k - 1) % 40) / 4;
    w = words[f];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return w[b-1];
  endfunction

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    if0.i_Tx_DV = 1'b1; if1.i_Tx_DV = 1'b1; if2.i_Tx_DV = 1'b1; if3.i_Tx_DV = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if0.i_Tx_DV = 1'b0; if1.i_Tx_DV = 1'b0; if2.i_Tx_DV = 1'b0; if3.i_Tx_DV = 1'b0;
    checks++;
    if (if0.o_Tx_Serial !== 1'b1) begin
      failures++; $display("FAIL reset_serial got=%b want=1", if0.o_Tx_Serial);
    end
    checks++;
    if (if0.o_Tx_Active !== 1'b0) begin
      failures++; $display("FAIL reset_active got=%b want=0", if0.o_Tx_Active);
    end
    checks++;
    if (if0.o_Tx_Done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b want=0", if0.o_Tx_Done);
    end
    checks++;
    if (if0.o_Tx_Ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", if0.o_Tx_Ready);
    end
    checks++;
    if (if0.o_Fifo_Count !== 3'd0) begin
      failures++; $display("FAIL reset_count got=%0d want=0", if0.o_Fifo_Count);
    end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if0.o_Tx_Active !== 1'b0 || if0.o_Tx_Serial !== 1'b1 ||
          if3.o_Tx_Active !== 1'b0 || if1.o_Fifo_Count !== 3'd0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL reset_no_frame got=%b want=0", seen);
    end
  endtask

  task automatic test_8n1_frame();
    logic [9:0] exp_bits;
    logic       exp_ser;
    exp_bits = 10'b1_10100101_0;
    if0.i_Tx_Byte = 8'hA5;
    if0.i_Tx_DV   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.i_Tx_DV = 1'b0;
    checks++;
    if (if0.o_Fifo_Count !== 3'd1 || if0.o_Tx_Serial !== 1'b1) begin
      failures++;
      $display("FAIL 8n1_after_push got=cnt%0d/ser%b want=cnt1/ser1",
               if0.o_Fifo_Count, if0.o_Tx_Serial);
    end
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      exp_ser = (k <= 40) ? exp_bits[(k-1)/4] : 1'b1;
      checks++;
      if (if0.o_Tx_Serial !== exp_ser) begin
        failures++; $display("FAIL 8n1_serial k=%0d got=%b want=%b", k, if0.o_Tx_Serial, exp_ser);
      end
      checks++;
      if (if0.o_Tx_Active !== (k <= 40)) begin
        failures++; $display("FAIL 8n1_active k=%0d got=%b want=%b", k, if0.o_Tx_Active, k <= 40);
      end
      checks++;
      if (if0.o_Tx_Done !== (k == 41)) begin
        failures++; $display("FAIL 8n1_done k=%0d got=%b want=%b", k, if0.o_Tx_Done, k == 41);
      end
      if (k == 1) begin
        checks++;
        if (if0.o_Fifo_Count !== 3'd0) begin
          failures++; $display("FAIL 8n1_count_pop got=%0d want=0", if0.o_Fifo_Count);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [19:0] exp_e;
    logic [19:0] exp_o;
    logic        want_e;
    logic        want_o;
    exp_e = {10'b1_1_0000111_0, 10'b1_0_0000011_0};
    exp_o = {10'b1_0_0000111_0, 10'b1_1_0000011_0};
    if1.i_Tx_Byte = 7'h03; if2.i_Tx_Byte = 7'h03;
    if1.i_Tx_DV = 1'b1;    if2.i_Tx_DV = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.i_Tx_Byte = 7'h07; if2.i_Tx_Byte = 7'h07;
    @(posedge clk);
    @(negedge clk);
    if1.i_Tx_DV = 1'b0;    if2.i_Tx_DV = 1'b0;
    for (int k = 1; k <= 81; k++) begin
      if (k > 1) @(negedge clk);
      want_e = (k <= 80) ? exp_e[(k-1)/4] : 1'b1;
      want_o = (k <= 80) ? exp_o[(k-1)/4] : 1'b1;
      checks++;
      if (if1.o_Tx_Serial !== want_e) begin
        failures++; $display("FAIL even_serial k=%0d got=%b want=%b", k, if1.o_Tx_Serial, want_e);
      end
      checks++;
      if (if2.o_Tx_Serial !== want_o) begin
        failures++; $display("FAIL odd_serial k=%0d got=%b want=%b", k, if2.o_Tx_Serial, want_o);
      end
      checks++;
      if (if1.o_Tx_Done !== (k == 41 || k == 81) || if2.o_Tx_Done !== (k == 41 || k == 81)) begin
        failures++;
        $display("FAIL parity_done k=%0d got=%b%b want=%b", k, if1.o_Tx_Done, if2.o_Tx_Done,
                 k == 41 || k == 81);
      end
      checks++;
      if (if1.o_Tx_Active !== (k <= 80)) begin
        failures++; $display("FAIL parity_active k=%0d got=%b want=%b", k, if1.o_Tx_Active, k <= 80);
      end
    end
  endtask

  task automatic test_two_stop();
    logic [21:0] exp_bits;
    logic        want;
    exp_bits = {11'b11_00000000_0, 11'b11_11111111_0};
    if3.i_Tx_Byte = 8'hFF;
    if3.i_Tx_DV   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if3.i_Tx_Byte = 8'h00;
    @(posedge clk);
    @(negedge clk);
    if3.i_Tx_DV = 1'b0;
    for (int k = 1; k <= 89; k++) begin
      if (k > 1) @(negedge clk);
      want = (k <= 88) ? exp_bits[(k-1)/4] : 1'b1;
      checks++;
      if (if3.o_Tx_Serial !== want) begin
        failures++; $display("FAIL 8n2_serial k=%0d got=%b want=%b", k, if3.o_Tx_Serial, want);
      end
      checks++;
      if (if3.o_Tx_Active !== (k <= 88)) begin
        failures++; $display("FAIL 8n2_active k=%0d got=%b want=%b", k, if3.o_Tx_Active, k <= 88);
      end
      checks++;
      if (if3.o_Tx_Done !== (k == 45 || k == 89)) begin
        failures++;
        $display("FAIL 8n2_done k=%0d got=%b want=%b", k, if3.o_Tx_Done, k == 45 || k == 89);
      end
    end
  endtask

  task automatic test_fifo_full();
    int   exp_cnt [6];
    logic exp_rdy [6];
    int   want_cnt;
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      if0.i_Tx_Byte = words[i];
      if0.i_Tx_DV   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (if0.o_Fifo_Count !== 3'(exp_cnt[i]) || if0.o_Tx_Ready !== exp_rdy[i]) begin
        failures++;
        $display("FAIL fill_level i=%0d got=cnt%0d/rdy%b want=cnt%0d/rdy%b", i,
                 if0.o_Fifo_Count, if0.o_Tx_Ready, exp_cnt[i], exp_rdy[i]);
      end
      if (i >= 1) begin
        checks++;
        if (if0.o_Tx_Serial !== fifo_bit(i)) begin
          failures++;
          $display("FAIL fill_serial k=%0d got=%b want=%b", i, if0.o_Tx_Serial, fifo_bit(i));
        end
      end
    end
    if0.i_Tx_DV = 1'b0;
    for (int k = 6; k <= 210; k++) begin
      @(negedge clk);
      want_cnt = (k < 41) ? 4 : (k < 81) ? 3 : (k < 121) ? 2 : (k < 161) ? 1 : 0;
      checks++;
      if (if0.o_Tx_Serial !== fifo_bit(k)) begin
        failures++; $display("FAIL drain_serial k=%0d got=%b want=%b", k, if0.o_Tx_Serial, fifo_bit(k));
      end
      checks++;
      if (if0.o_Fifo_Count !== 3'(want_cnt) || if0.o_Tx_Ready !== (want_cnt < 4)) begin
        failures++;
        $display("FAIL drain_level k=%0d got=cnt%0d/rdy%b want=cnt%0d/rdy%b", k,
                 if0.o_Fifo_Count, if0.o_Tx_Ready, want_cnt, want_cnt < 4);
      end
      checks++;
      if (if0.o_Tx_Active !== (k <= 200) ||
          if0.o_Tx_Done !== (k >= 41 && k <= 201 && (k % 40) == 1)) begin
        failures++;
        $display("FAIL drain_flags k=%0d got=act%b/done%b", k, if0.o_Tx_Active, if0.o_Tx_Done);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic bad;
    logic [7:0] mw [3];
    mw = '{8'hF0, 8'h12, 8'h34};
    for (int i = 0; i < 3; i++) begin
      if0.i_Tx_Byte = mw[i];
      if0.i_Tx_DV   = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    if0.i_Tx_DV = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (if0.o_Tx_Serial !== 1'b0 || if0.o_Fifo_Count !== 3'd2 || if0.o_Tx_Active !== 1'b1) begin
      failures++;
      $display("FAIL midframe_pre got=ser%b/cnt%0d/act%b want=ser0/cnt2/act1",
               if0.o_Tx_Serial, if0.o_Fifo_Count, if0.o_Tx_Active);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (if0.o_Tx_Serial !== 1'b1 || if0.o_Fifo_Count !== 3'd0 || if0.o_Tx_Active !== 1'b0 ||
        if0.o_Tx_Done !== 1'b0 || if0.o_Tx_Ready !== 1'b1) begin
      failures++;
      $display("FAIL midframe_reset got=ser%b/cnt%0d/act%b/done%b/rdy%b want=1/0/0/0/1",
               if0.o_Tx_Serial, if0.o_Fifo_Count, if0.o_Tx_Active, if0.o_Tx_Done,
               if0.o_Tx_Ready);
    end
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if0.o_Tx_Serial !== 1'b1 || if0.o_Tx_Active !== 1'b0 || if0.o_Tx_Done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL midframe_quiet got=%b want=0", bad);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    if0.i_Tx_DV = 1'b1; if1.i_Tx_DV = 1'b1; if2.i_Tx_DV = 1'b1; if3.i_Tx_DV = 1'b1;
    if0.i_Tx_Byte = 8'h00; if1.i_Tx_Byte = 7'h00; if2.i_Tx_Byte = 7'h00; if3.i_Tx_Byte = 8'h00;
    words = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    test_reset();
    test_8n1_frame();
    repeat (3) @(negedge clk);
    test_parity();
    repeat (3) @(negedge clk);
    test_two_stop();
    repeat (3) @(negedge clk);
    test_fifo_full();
    repeat (3) @(negedge clk);
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a configurable frame format (data bits, parity, stop bits) and an internal transmit FIFO. It accepts words over a ready/valid handshake and serialises them LSB-first onto `o_Tx_Serial`. Queued frames go out back-to-back with no idle gap. It is the general-purpose TX engine for the board's debug/console links and replaces fixed 8N1, single-byte transmitters.

## Interface
- `CLKS_PER_BIT`, 5000: clock cycles per serial bit, equal to f_clk / baud. Must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. Other values are illegal.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Power of two, ≥ 2.
- `i_Clock`  in  1: sole clock; all logic is on its rising edge.
- `i_Reset`  in  1: synchronous, active-high reset.
- `i_Tx_DV`  in  1: write valid.
- `i_Tx_Byte`  in  DATA_BITS: word to transmit.
- `o_Tx_Ready`  out  1: FIFO can accept a word; equals `!full`.
- `o_Tx_Serial`  out  1: serial line, idle high.
- `o_Tx_Active`  out  1: a frame is on the line.
- `o_Tx_Done`  out  1: one-cycle pulse at the end of each frame.
- `o_Fifo_Count`  out  $clog2(FIFO_DEPTH)+1: number of words queued; excludes the word currently in the shifter.

## Operation
- **Reset.** Takes effect on the edge where `i_Reset`=1 and overrides everything else.
  - FIFO is emptied; `o_Fifo_Count`=0; `o_Tx_Ready`=1.
  - `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0.
  - FSM goes to IDLE; bit and clock counters are 0.
- **Push.** A word is written on every edge with `i_Tx_DV & o_Tx_Ready`. `i_Tx_DV` while full is ignored; no overwrite, no error flag.
- **Pop.** Occurs in IDLE, or at the final cycle of the last stop bit, whenever the FIFO is non-empty.
- **Push and pop on the same edge.** Both take effect; the count is unchanged. Pushing into an empty FIFO cannot pop that word on the same edge.
- **FSM states:** IDLE → START → DATA → PARITY (only if `PARITY`≠0) → STOP → IDLE or START.
  - IDLE: drive 1. If the FIFO is non-empty, pop, latch the word and its parity, drive 0, and go to START.
  - START, DATA, PARITY, STOP: each bit is held for exactly CLKS_PER_BIT cycles; the clock counter runs 0..CLKS_PER_BIT-1, then wraps to 0.
  - DATA sends bit 0 first, for DATA_BITS bits.
  - Parity bit: even = XOR of the data bits; odd = the inverse of that.
  - STOP drives 1 for STOP_BITS × CLKS_PER_BIT cycles.
- **End of the last stop cycle.**
  - `o_Tx_Done` pulses for 1 cycle.
  - If the FIFO is non-empty: pop and go straight to START (line goes 0 on the next edge with no idle cycle), and `o_Tx_Active` stays 1.
  - Otherwise: go to IDLE and drop `o_Tx_Active`.
- **Reset mid-frame.** The frame is aborted and the line returns high on the next edge. No `o_Tx_Done` is generated.
- **Counter widths.** The clock counter is $clog2(CLKS_PER_BIT)+1 bits. The bit index is $clog2(DATA_BITS) bits. FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- **Frame length:** F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Latency from an idle, empty block.**
  - Push at edge E0.
  - At E1: `o_Tx_Serial` falls, `o_Tx_Active` rises, `o_Fifo_Count` returns to 0.
- **Serial waveform.** Bit k of the frame occupies edges E1+k·CLKS_PER_BIT through E1+(k+1)·CLKS_PER_BIT−1.
- **End of frame.** `o_Tx_Done` is high for the single cycle after edge E1+F; `o_Tx_Active` falls on the same edge E1+F.
- **Back-to-back frames.** Start-bit edges are exactly F cycles apart.
- **Ready.** `o_Tx_Ready` falls on the edge that makes the count equal FIFO_DEPTH. It rises on the edge of the next pop.

## Test plan
- **Reset.** Assert `i_Reset` for 2 cycles with `i_Tx_DV`=1 → after release: Serial=1, Active=0, Done=0, Ready=1, Count=0, and no frame starts.
- **8N1 frame.** CLKS_PER_BIT=4, push 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting one edge after the push. Done pulses once at 40 cycles; Active is high for exactly 40 cycles.
- **Parity.** DATA_BITS=7, CLKS_PER_BIT=4.
  - PARITY=2, push 0x03 → parity bit 0.
  - PARITY=1, push 0x03 → parity bit 1.
  - Push 0x07 with each mode → the parity bits invert relative to the 0x03 case.
  - Frame length is 40 cycles.
- **Two stop bits.** STOP_BITS=2, push 0xFF then 0x00 → the line is high for 8 cycles between the last data bit and the next start bit. Start edges are 44 cycles apart, and Active never drops.
- **FIFO full and drain.** FIFO_DEPTH=4, push 6 words on consecutive cycles.
  - Words 1–5 are accepted (one is popped at E1), Ready falls, and word 6 is dropped.
  - Five frames are sent back-to-back in order; Count steps 4→3→2→1→0.
  - Ready rises at the first in-frame pop.
- **Reset mid-frame.** Pulse `i_Reset` during data bit 3 with 2 words queued → Serial=1 on the next edge, Count=0, no Done, and no further frames are sent.
